board_io: RTL
=============

# board_io

Board-level I/O conditioning block between the physical pins and `game_top`. Normalises per-bit key and LED polarity via parameter masks. Synchronises and debounces keys into clean active-high levels plus one-cycle press/release pulses. Also stretches the board reset into a registered active-high core reset.

## Interface
Parameters:
- `KEYS_W`, default 4: number of key inputs.
- `LEDS_W`, default 8: number of LED outputs.
- `KEYS_POL`, default all-ones: per-key mask; bit 1 means the pin is active-low.
- `LEDS_POL`, default all-ones: per-LED mask; bit 1 means the LED is lit by driving 0.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key change; minimum 1.
- `RST_STRETCH`, default 16: cycles `rst_o` stays high after reset release; minimum 0.
- `REPEAT_DELAY`, default 25000000: cycles held before the first auto-repeat pulse (auto-repeat builds only).
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses (auto-repeat builds only).

Ports:
- `clk_i` input 1: the single clock.
- `rst_n_i` input 1: reset, synchronous, active-low.
- `keys_i` input KEYS_W: raw key pins.
- `leds_i` input LEDS_W: active-high LED requests from the core.
- `keys_o` output KEYS_W: debounced active-high key levels.
- `keys_press_o` output KEYS_W: one-cycle pulse per accepted press (and per repeat, if enabled).
- `keys_release_o` output KEYS_W: one-cycle pulse per accepted release.
- `leds_o` output LEDS_W: LED pins, polarity applied.
- `rst_o` output 1: active-high core reset.

## Operation
- Normalisation: `keys_i ^ KEYS_POL` (combinational) feeds a 2-flop synchroniser per bit, producing `sync[i]`.
- Debounce, per key: keep state `stable[i]` and counter `cnt[i]`, where `cnt[i]` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - If `sync == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are discarded, and the counter restarts on every bounce.
- `keys_o = stable`, registered.
- `keys_press_o[i]` is high exactly in the first cycle that `keys_o[i]` is 1. `keys_release_o[i]` is high exactly in the first cycle that `keys_o[i]` is 0 after being 1. Both are registered, with no extra cycle.
- LEDs: `leds_o <= leds_i ^ LEDS_POL`, one register stage.
- Reset stretcher: counter `rcnt`, `$clog2(RST_STRETCH+1)` bits.
  - While `rst_n_i == 0`: `rcnt <= RST_STRETCH` and `rst_o <= 1`.
  - Otherwise, if `rcnt != 0`: decrement `rcnt` and hold `rst_o = 1`.
  - When `rcnt == 0`: `rst_o <= 0`.
- Keys are independent of each other. Simultaneous presses on several bits produce pulses in the same cycle.

## Timing
- Reset values, all synchronous:
  - `sync`, `stable`, `cnt`: 0.
  - `keys_o`, `keys_press_o`, `keys_release_o`: 0.
  - `leds_o`: `LEDS_POL` (all LEDs off).
  - `rst_o`: 1.
- Key latency: a clean raw edge before clock edge 0 gives `keys_o` and the pulse updating after edge `2 + DEBOUNCE_CYCLES`.
- LED latency: 1 cycle.
- `rst_o` deasserts `RST_STRETCH + 1` cycles after the first edge that samples `rst_n_i == 1`. With `RST_STRETCH == 0`, it deasserts after 1 cycle.
- Reset asserted mid-debounce or mid-repeat aborts the operation: counters clear and no pulse is issued on the reset cycle or the cycle after.
- A key already held when reset releases is accepted `2 + DEBOUNCE_CYCLES` cycles later and produces a press pulse.

## Configuration
- `BOARD_IO_AUTOREPEAT_EN` defined:
  - Adds a per-key repeat counter, cleared whenever `keys_o[i] == 0`.
  - While the key is held, `keys_press_o[i]` pulses again `REPEAT_DELAY` cycles after the initial press pulse, then every `REPEAT_PERIOD` cycles.
  - The counter stops at release; the release pulse is unaffected.
- Undefined: no repeat logic is built, and exactly one press pulse is issued per accepted press. `REPEAT_*` parameters are ignored.

## Test plan
- Reset: hold `rst_n_i = 0` for 5 cycles with `LEDS_POL = 8'hFF` -> `leds_o = 8'hFF`, `rst_o = 1`, all key outputs 0. Release -> `rst_o` falls after exactly `RST_STRETCH + 1` cycles.
- Clean press: `DEBOUNCE_CYCLES = 4`, `keys_i[0]` 1 -> 0 (active-low) -> `keys_o[0]` rises 6 cycles later, with a 1-cycle `keys_press_o[0]`. Releasing gives a 1-cycle `keys_release_o[0]` 6 cycles later.
- Bounce: toggle `keys_i[1]` with 3-cycle pulses for 20 cycles, then hold low -> no pulse during bouncing; one press pulse 6 cycles after the final edge.
- Polarity/LEDs: `KEYS_POL[2] = 0`, `LEDS_POL = 8'h0F`, `leds_i = 8'h81` -> active-high key 2 is accepted on 0 -> 1; `leds_o = 8'h8E` one cycle later.
- Mid-operation reset: assert `rst_n_i` while key 3 is 2 cycles into debounce -> `cnt` cleared and no pulse; after release the held key is accepted `2 + DEBOUNCE_CYCLES` later.
- Autorepeat (`BOARD_IO_AUTOREPEAT_EN`, `REPEAT_DELAY = 10`, `REPEAT_PERIOD = 4`): hold key 0 for 30 cycles after acceptance -> press pulses at +0, +10, +14, +18, +22, +26; none after release.

Source files
------------

// File: rtl/board_io.sv
// Board pin conditioning: key/LED polarity, 2-flop key sync + debounce with press/release pulses, reset stretcher.
// Optional auto-repeat of press pulses when BOARD_IO_AUTOREPEAT_EN is defined.
module board_io #(
  parameter int                 KEYS_W          = 4,
  parameter int                 LEDS_W          = 8,
  parameter logic [KEYS_W-1:0]  KEYS_POL        = '1,
  parameter logic [LEDS_W-1:0]  LEDS_POL        = '1,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 RST_STRETCH     = 16,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [KEYS_W-1:0] keys_i,
  input  logic [LEDS_W-1:0] leds_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] keys_press_o,
  output logic [KEYS_W-1:0] keys_release_o,
  output logic [LEDS_W-1:0] leds_o,
  output logic              rst_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(RST_STRETCH);

  if (DEBOUNCE_CYCLES < 1 || RST_STRETCH < 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
    $error("board_io: parameter out of range");
  end

  logic [KEYS_W-1:0] sync_p0;
  logic [KEYS_W-1:0] sync_p1;
  logic [KEYS_W-1:0] stable_p2;
  logic [CNT_W-1:0]  cnt_p2 [KEYS_W];
  logic [KEYS_W-1:0] rep_fire;
  logic [RCNT_W-1:0] rcnt;

  // Stage p0/p1: polarity normalisation and two-flop synchroniser
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= keys_i ^ KEYS_POL;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; any bounce back to the stable value restarts the count
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stable_p2 <= '0;
      for (int i = 0; i < KEYS_W; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < KEYS_W; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          stable_p2[i] <= sync_p1[i];
          cnt_p2[i]    <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BOARD_IO_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]  rep_cnt [KEYS_W];
  logic [KEYS_W-1:0] rep_on;

  // A repeat fires only while the key is both shown held and still debounced held
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < KEYS_W; i++) begin
      rep_fire[i] = keys_o[i] & stable_p2[i] &
                    (rep_cnt[i] == (rep_on[i] ? REP_PER_LAST : REP_DLY_LAST));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rep_on <= '0;
      for (int i = 0; i < KEYS_W; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEYS_W; i++) begin
        if (!(keys_o[i] & stable_p2[i])) begin
          rep_cnt[i] <= '0;
          rep_on[i]  <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i] <= '0;
          rep_on[i]  <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  // Stage p3: registered levels and edge pulses, aligned with keys_o
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      keys_o         <= '0;
      keys_press_o   <= '0;
      keys_release_o <= '0;
    end else begin
      keys_o         <= stable_p2;
      keys_press_o   <= (stable_p2 & ~keys_o) | rep_fire;
      keys_release_o <= ~stable_p2 & keys_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) leds_o <= LEDS_POL;
    else          leds_o <= leds_i ^ LEDS_POL;
  end

  // Reset stretcher: rst_o stays high until rcnt has counted down and one more edge passes
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rcnt  <= RCNT_INIT;
      rst_o <= 1'b1;
    end else if (rcnt != '0) begin
      rcnt  <= rcnt - RCNT_W'(1);
      rst_o <= 1'b1;
    end else begin
      rst_o <= 1'b0;
    end
  end

endmodule
